p_encoder: RTL and testbench
============================

P_ENCODER -- requirements
Module: p_encoder

Interface
REQ-001 Parameters: none; input width fixed at 8, code width fixed at 3.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 d  input  8  request vector; d[7] highest priority, d[0] lowest.
REQ-005 y0  output  1  encoded index bit 0 (LSB), registered.
REQ-006 y1  output  1  encoded index bit 1, registered.
REQ-007 y2  output  1  encoded index bit 2 (MSB), registered.
REQ-008 v  output  1  valid: high when the sampled d had at least one bit set, registered.

Function
REQ-009 Encoding SHALL be {y2,y1,y0} = index k of the highest-numbered bit of d equal to 1.
REQ-010 Bits of d below the winning bit k SHALL NOT affect the outputs, including when they are 0, 1, X or Z.
REQ-011 d = 8'b0000_0000 SHALL yield {y2,y1,y0}=3'b000 with v=0; any nonzero d SHALL yield v=1.
REQ-012 Latency SHALL be exactly 1 cycle: outputs after rising edge n reflect d sampled at edge n; outputs hold between edges.
REQ-013 Outputs SHALL be driven only from flops; no combinational path from d to any output.
REQ-014 There SHALL be no handshake and no input enable; d is sampled every cycle.
REQ-015 d changing between edges SHALL have no effect until the next rising edge.
REQ-016 If bits above the winning bit are X/Z, outputs SHALL be X in simulation; no X-masking above the winner is required.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk, force y2=y1=y0=0 and v=0.
REQ-018 Outputs SHALL stay at reset values while rst_n=0, regardless of clk and d.
REQ-019 After rst_n rises, the first rising edge SHALL capture d normally; a reset asserted mid-stream SHALL discard the pending encoding.

Structure
REQ-020 No shared package is required; the index width of 3 SHALL be a localparam inside the module.
REQ-021 A combinational sub-module p_encoder_core (d[7:0] -> idx[2:0], any) SHALL hold the priority logic; p_encoder SHALL add only the output registers.
REQ-022 The priority logic SHALL be a highest-bit-first casez/if-else chain so that don't-care low bits match.

Verification
REQ-023 Reset: rst_n=0 with d=8'hFF -> y2,y1,y0,v = 0,0,0,0 immediately and across clk edges.
REQ-024 Walking priority, one edge each: d=00000001, 0000001x, 000001xx, 00001xxx, 0001xxxx, 001xxxxx, 01xxxxxx, 1xxxxxxx -> {y2,y1,y0}=000,001,010,011,100,101,110,111 with v=1, one cycle after each sample.
REQ-025 Multiple bits set: d=8'b0101_0110 -> {y2,y1,y0}=110, v=1; d=8'b1000_0001 -> 111, v=1.
REQ-026 Zero input: d=8'h00 -> {y2,y1,y0}=000, v=0 after the next edge.
REQ-027 Latency/async reset: change d between edges -> outputs unchanged until the edge; pulse rst_n low mid-cycle -> outputs 0 at once, then d=8'h10 -> 100, v=1 on the first edge after release.

Source files
------------

// File: rtl/p_encoder_pkg.sv
// ---------------------------------------------------------------------------
// p_encoder_pkg
// Shared widths and the registered-result type for the 8-to-3 priority
// encoder. Only the request width and the result layout live here; the
// index width itself stays a localparam inside each module.
// ---------------------------------------------------------------------------
package p_encoder_pkg;

    localparam int unsigned REQ_W = 8;

    // Registered encoder result: valid flag plus encoded index.
    typedef struct packed {
        logic       v;
        logic [2:0] idx;
    } enc_result_t;

endpackage : p_encoder_pkg

// File: rtl/p_encoder_core.sv
// ---------------------------------------------------------------------------
// p_encoder_core
// Purely combinational priority logic. The highest-numbered set bit of d
// wins. The result does not depend on any bit below the winner.
//
// Ports:
//   d   [7:0] in  : request vector, d[7] highest priority
//   idx [2:0] out : index of the highest set bit (0 when d is all zero)
//   any       out : high when at least one bit of d is set
// ---------------------------------------------------------------------------
module p_encoder_core
    import p_encoder_pkg::*;
(
    input  logic [REQ_W-1:0] d,
    output logic [2:0]       idx,
    output logic             any
);

    localparam int unsigned IDX_W = 3;

    // Highest bit first. The '?' positions are don't-cares, so bits below
    // the winner cannot change the result.
    always_comb begin
        idx = '0;
        any = 1'b0;
        casez (d)
            8'b1???????: begin idx = IDX_W'(7); any = 1'b1; end
            8'b01??????: begin idx = IDX_W'(6); any = 1'b1; end
            8'b001?????: begin idx = IDX_W'(5); any = 1'b1; end
            8'b0001????: begin idx = IDX_W'(4); any = 1'b1; end
            8'b00001???: begin idx = IDX_W'(3); any = 1'b1; end
            8'b000001??: begin idx = IDX_W'(2); any = 1'b1; end
            8'b0000001?: begin idx = IDX_W'(1); any = 1'b1; end
            8'b00000001: begin idx = IDX_W'(0); any = 1'b1; end
            default:     begin idx = '0;        any = 1'b0; end
        endcase
    end

endmodule : p_encoder_core

// File: rtl/p_encoder.sv
// ---------------------------------------------------------------------------
// p_encoder
// Registered 8-to-3 priority encoder. d is sampled on every rising clk edge.
// There is no enable and no handshake. The outputs after edge n reflect d
// at edge n. Every output comes straight from a flop.
//
// Ports:
//   clk        in  : clock, rising edge active
//   rst_n      in  : asynchronous active-low reset; clears all outputs
//   d    [7:0] in  : request vector, d[7] highest priority
//   y0/y1/y2   out : encoded index bits (y0 = LSB), registered
//   v          out : registered "some bit of d was set"
// ---------------------------------------------------------------------------
module p_encoder
    import p_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REQ_W-1:0] d,
    output logic             y0,
    output logic             y1,
    output logic             y2,
    output logic             v
);

    localparam int unsigned IDX_W = 3;

    logic [IDX_W-1:0] w_idx;
    logic             w_any;
    enc_result_t      r_result;

    p_encoder_core u_core (
        .d   (d),
        .idx (w_idx),
        .any (w_any)
    );

    // Reset drops the outputs at once and discards any pending encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else begin
            r_result.v   <= w_any;
            r_result.idx <= w_idx;
        end
    end

    assign y0 = r_result.idx[0];
    assign y1 = r_result.idx[1];
    assign y2 = r_result.idx[2];
    assign v  = r_result.v;

endmodule : p_encoder

// File: tb/tb_p_encoder.sv
// ---------------------------------------------------------------------------
// tb_p_encoder
// Bench for p_encoder. Inputs change on the falling edge. Outputs are sampled
// 1 time unit after the rising edge. Expected results are {v,y2,y1,y0}.
// ---------------------------------------------------------------------------
module tb_p_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       y0, y1, y2, v;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [3:0]  exp_q[$];

    p_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (d),
        .y0    (y0),
        .y1    (y1),
        .y2    (y2),
        .v     (v)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. It scans from the LSB upward, so the last set bit wins.
    function automatic logic [3:0] ref_enc(input logic [7:0] din);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            if (din[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    function automatic logic [3:0] dut_out();
        return {v, y2, y1, y0};
    endfunction

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got {v,y2,y1,y0}=%b expected %b", tag, obs, exp);
        end
    endtask

    // Scoreboard pop: compare the current outputs with the oldest expectation.
    task automatic compare_out(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got output with empty expected queue", tag);
        end else begin
            e = exp_q.pop_front();
            check(tag, dut_out(), e);
        end
    endtask

    // Driver: one sample per cycle.
    task automatic apply(input logic [7:0] din, input logic [3:0] exp,
                         input string tag);
        @(negedge clk);
        d = din;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        logic [7:0] r8;
        logic [7:0] walk;
        n_checks = 0;
        n_errors = 0;

        // Reset behaviour with all requests set.
        rst_n = 1'b0;
        d     = 8'hFF;
        #1;
        check("reset_immediate", dut_out(), 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", dut_out(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Walking priority with random low bits below the winner.
        for (int k = 0; k < 8; k++) begin
            r8   = 8'($urandom_range(0, 255));
            walk = 8'(1 << k);
            walk = walk | (r8 & (walk - 8'd1));
            apply(walk, {1'b1, 3'(k)}, $sformatf("walk_%0d", k));
        end

        // Multiple bits set, and zero input.
        apply(8'b0101_0110, 4'b1110, "multi_56");
        apply(8'b1000_0001, 4'b1111, "multi_81");
        apply(8'h00,        4'b0000, "zero");

        // Random vectors against the reference model.
        for (int i = 0; i < 24; i++) begin
            r8 = 8'($urandom_range(0, 255));
            apply(r8, ref_enc(r8), "random");
        end
        apply(8'h00, 4'b0000, "zero_again");

        // A change between edges must not reach the outputs before the next edge.
        apply(8'h80, 4'b1111, "pre_latency");
        #2;
        d = 8'h01;
        #1;
        check("hold_between_edges", dut_out(), 4'b1111);
        @(posedge clk);
        #1;
        check("after_edge", dut_out(), 4'b1000);

        // An asynchronous reset in mid-cycle discards the pending result.
        @(negedge clk);
        d = 8'h40;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_now", dut_out(), 4'b0000);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("async_reset_edge", dut_out(), 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        apply(8'h10, 4'b1100, "after_reset_10");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d leftover expectations expected 0",
                     exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety bound on run time.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish by 100000");
        $fatal(1);
    end

endmodule : tb_p_encoder
